square_motion_ctrl: RTL
=======================

SQUARE_MOTION_CTRL -- requirements
Module: square_motion_ctrl

Interface
REQ-001 The block SHALL have parameter STEP, default 2, giving pixels moved per frame per axis; legal range 1..16.
REQ-002 The block SHALL have port clk, input, 1, system clock at 50 MHz.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port vsync, input, 1, vertical sync from the VGA timing block, asynchronous to this block's sampling.
REQ-005 The block SHALL have port btn, input, 4, raw push-buttons {up, down, left, right} = btn[3:0], active-high and asynchronous.
REQ-006 The block SHALL have port mode_sel, input, 1, where 0 = manual and 1 = auto-bounce; it is asynchronous.
REQ-007 The block SHALL have port xPixel, output, 16, square centre column fed to the VGA block.
REQ-008 The block SHALL have port yPixel, output, 16, square centre row fed to the VGA block.
REQ-009 The block SHALL have port frame_upd, output, 1, a one-cycle pulse marking each position update.
REQ-010 The block SHALL have port state_o, output, 2, current FSM state encoding for debug.

Function
REQ-011 vsync, btn and mode_sel SHALL each pass through a 2-flop synchroniser; vsync additionally feeds a third flop for edge detection.
REQ-012 frame tick SHALL be the synchronised vsync being 1 while the third-flop copy is 0; there is exactly one tick per vsync rising edge.
REQ-013 All position, direction and state registers SHALL update only on the clk edge where tick=1: new values are visible after the 3rd rising clk edge following the first edge that samples vsync high.
REQ-014 frame_upd SHALL be registered, high for exactly the cycle in which the new xPixel/yPixel first appear, and low otherwise, including ticks in which the position is unchanged.
REQ-015 Legal bounds SHALL be X in 5..633 and Y in 5..473, so that the 12x12 square (centre-5 .. centre+6) stays inside the 640x480 area.
REQ-016 The FSM SHALL have three states, IDLE=0, MANUAL=1 and BOUNCE=2, and evaluate transitions on the tick using the synchronised inputs.
REQ-017 IDLE: if mode_sel=1, go to BOUNCE; else if any btn=1, go to MANUAL and apply that tick's move; else hold position.
REQ-018 MANUAL: if mode_sel=1, go to BOUNCE; else if no btn=1, go to IDLE; else move per REQ-019.
REQ-019 Manual move: up subtracts STEP from Y, down adds STEP, left subtracts STEP from X and right adds STEP; opposing buttons pressed together cancel on that axis; the result is clamped to the bounds with no wrap-around.
REQ-020 BOUNCE: if mode_sel=0, go to IDLE and freeze position; else move X by dx*STEP and Y by dy*STEP.
REQ-021 In BOUNCE, when a next coordinate would fall outside its bound, the coordinate SHALL be clamped to that bound and that axis's direction flipped in the same tick; the two axes are handled independently, and a corner hit flips both.
REQ-022 Next-position arithmetic SHALL be done in 17-bit signed so that underflow below 0 is detected before clamping; outputs are zero-extended to 16 bits.
REQ-023 dx/dy SHALL be retained across IDLE/MANUAL so that BOUNCE resumes in the last direction.
REQ-024 Button or mode changes between ticks SHALL have no effect; only the level sampled at the tick counts.

Reset
REQ-025 While rst_n=0, outputs SHALL be xPixel=320, yPixel=240 and frame_upd=0, with state=IDLE, dx=+1, dy=+1 and all synchroniser flops cleared.
REQ-026 Reset assertion mid-frame SHALL take effect immediately (asynchronously); after release, the first update occurs only on a fresh vsync rising edge, and a vsync already high at release produces no tick.

Structure
REQ-027 A package sq_pkg SHALL hold the state enum, the constants X_MIN=5, X_MAX=633, Y_MIN=5, Y_MAX=473, X_RST=320 and Y_RST=240, and the 640/480 display sizes.
REQ-028 A sub-module sync_2ff (1-bit, async active-low reset to 0) SHALL be instantiated for each asynchronous input bit.
REQ-029 The FSM, the arithmetic and the clamp logic SHALL reside in square_motion_ctrl.

Verification
REQ-030 Reset, no buttons, mode 0, 3 vsync pulses -> xPixel=320, yPixel=240, 3 frame_upd pulses, state IDLE.
REQ-031 STEP=2, hold right for 5 frames, then nothing -> x=322,324,326,328,330, then hold at 330; state goes MANUAL, then IDLE.
REQ-032 Hold up+left with x=6, y=6 -> after one tick x=5, y=5, and further frames stay at 5,5 (clamped, no wrap).
REQ-033 STEP=4, BOUNCE from x=631, dx=+1 -> x=633 with dx flipped, next frame x=629; same check at y=471 -> 473 -> 469.
REQ-034 vsync held high across rst_n release -> no frame_upd until vsync goes low and rises again; rst_n pulsed mid-BOUNCE -> outputs return to 320/240 in the same cycle.
REQ-035 Toggle mode_sel 1->0->1 between ticks only -> no state change; toggle 1->0 at a tick -> IDLE, then 0->1 -> BOUNCE resumes with the retained dx/dy.

Source files
------------

// File: rtl/sq_pkg.sv
// Shared definitions for the square motion controller: FSM state encoding,
// display geometry, legal centre bounds and the signed clamp helper.
package sq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_MANUAL = 2'd1,
      ST_BOUNCE = 2'd2
   } state_e;

   localparam int H_SIZE = 640;
   localparam int V_SIZE = 480;

   // Centre limits keep the 12x12 square (centre-5 .. centre+6) on screen.
   localparam logic signed [16:0] X_MIN = 17'sd5;
   localparam logic signed [16:0] X_MAX = 17'sd633;
   localparam logic signed [16:0] Y_MIN = 17'sd5;
   localparam logic signed [16:0] Y_MAX = 17'sd473;

   localparam logic [15:0] X_RST = 16'd320;
   localparam logic [15:0] Y_RST = 16'd240;

   // Clamp a signed 17-bit candidate coordinate into [lo, hi]; the result
   // is always non-negative so the low 16 bits are the zero-extended value.
   function automatic logic [15:0] clamp_axis(input logic signed [16:0] v,
                                              input logic signed [16:0] lo,
                                              input logic signed [16:0] hi);
      if (v < lo) begin
         clamp_axis = lo[15:0];
      end else if (v > hi) begin
         clamp_axis = hi[15:0];
      end else begin
         clamp_axis = v[15:0];
      end
   endfunction

   // True when a candidate coordinate lies outside [lo, hi].
   function automatic logic out_of_range(input logic signed [16:0] v,
                                         input logic signed [16:0] lo,
                                         input logic signed [16:0] hi);
      out_of_range = (v < lo) || (v > hi);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for asynchronous inputs.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s1_d;
   logic s2_q;
   logic s2_d;

   // Shift the raw input down the two-stage chain.
   always_comb begin
      s1_d = d;
      s2_d = s1_q;
   end

   // Synchroniser flops, cleared by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/square_motion_ctrl.sv
// Moves a 12x12 square once per frame: manual button control or automatic
// wall-bouncing, with all state advancing only on the vsync rising-edge tick.
module square_motion_ctrl
   import sq_pkg::*;
#(
   parameter int STEP = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vsync,
   input  logic [3:0]  btn,
   input  logic        mode_sel,
   output logic [15:0] xPixel,
   output logic [15:0] yPixel,
   output logic        frame_upd,
   output logic [1:0]  state_o
);

   localparam logic signed [16:0] STEP_S = 17'(STEP);

   // Synchronised inputs
   logic       vsync_s;
   logic       mode_s;
   logic [3:0] btn_s;
   logic       any_btn_s;
   logic       tick_s;

   sync_2ff u_sync_vsync (.clk(clk), .rst_n(rst_n), .d(vsync),    .q(vsync_s));
   sync_2ff u_sync_mode  (.clk(clk), .rst_n(rst_n), .d(mode_sel), .q(mode_s));

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_btn_sync
         sync_2ff u_sync_btn (.clk(clk), .rst_n(rst_n), .d(btn[gi]), .q(btn_s[gi]));
      end
   endgenerate

   // Edge detection and tick arming. The arm flag is only set once the
   // synchroniser has refilled after reset and shows vsync low, so a vsync
   // already high at reset release cannot produce a tick.
   logic       vs3_q;
   logic       vs3_d;
   logic [1:0] fill_q;
   logic [1:0] fill_d;
   logic       armed_q;
   logic       armed_d;

   // Motion state
   state_e      state_q;
   state_e      state_d;
   logic [15:0] x_q;
   logic [15:0] x_d;
   logic [15:0] y_q;
   logic [15:0] y_d;
   logic        dx_neg_q;
   logic        dx_neg_d;
   logic        dy_neg_q;
   logic        dy_neg_d;
   logic        frame_upd_q;
   logic        frame_upd_d;

   // Arithmetic
   logic signed [16:0] x_ext_s;
   logic signed [16:0] y_ext_s;
   logic signed [16:0] man_dx_s;
   logic signed [16:0] man_dy_s;
   logic signed [16:0] man_x_sum_s;
   logic signed [16:0] man_y_sum_s;
   logic signed [16:0] bx_sum_s;
   logic signed [16:0] by_sum_s;

   assign any_btn_s = |btn_s;
   assign tick_s    = armed_q & vsync_s & ~vs3_q;
   assign x_ext_s   = {1'b0, x_q};
   assign y_ext_s   = {1'b0, y_q};

   // Edge-detect flop, post-reset fill tracker and arm flag next values.
   always_comb begin
      vs3_d   = vsync_s;
      fill_d  = {fill_q[0], 1'b1};
      armed_d = armed_q | (fill_q[1] & ~vsync_s);
   end

   // Manual deltas (opposing buttons cancel) and bounce candidates.
   // Buttons: btn[3]=up, btn[2]=down, btn[1]=left, btn[0]=right.
   always_comb begin
      man_dx_s = 17'sd0;
      man_dy_s = 17'sd0;
      if (btn_s[0] && !btn_s[1]) begin
         man_dx_s = STEP_S;
      end else if (btn_s[1] && !btn_s[0]) begin
         man_dx_s = -STEP_S;
      end else begin
         man_dx_s = 17'sd0;
      end
      if (btn_s[2] && !btn_s[3]) begin
         man_dy_s = STEP_S;
      end else if (btn_s[3] && !btn_s[2]) begin
         man_dy_s = -STEP_S;
      end else begin
         man_dy_s = 17'sd0;
      end
      man_x_sum_s = x_ext_s + man_dx_s;
      man_y_sum_s = y_ext_s + man_dy_s;
      bx_sum_s    = dx_neg_q ? (x_ext_s - STEP_S) : (x_ext_s + STEP_S);
      by_sum_s    = dy_neg_q ? (y_ext_s - STEP_S) : (y_ext_s + STEP_S);
   end

   // FSM next state, position and direction; everything holds between ticks.
   always_comb begin
      state_d     = state_q;
      x_d         = x_q;
      y_d         = y_q;
      dx_neg_d    = dx_neg_q;
      dy_neg_d    = dy_neg_q;
      frame_upd_d = tick_s;
      if (tick_s) begin
         case (state_q)
            ST_IDLE: begin
               if (mode_s) begin
                  state_d = ST_BOUNCE;
               end else if (any_btn_s) begin
                  state_d = ST_MANUAL;
                  x_d     = clamp_axis(man_x_sum_s, X_MIN, X_MAX);
                  y_d     = clamp_axis(man_y_sum_s, Y_MIN, Y_MAX);
               end else begin
                  state_d = ST_IDLE;
               end
            end
            ST_MANUAL: begin
               if (mode_s) begin
                  state_d = ST_BOUNCE;
               end else if (!any_btn_s) begin
                  state_d = ST_IDLE;
               end else begin
                  x_d = clamp_axis(man_x_sum_s, X_MIN, X_MAX);
                  y_d = clamp_axis(man_y_sum_s, Y_MIN, Y_MAX);
               end
            end
            ST_BOUNCE: begin
               if (!mode_s) begin
                  state_d = ST_IDLE;
               end else begin
                  x_d      = clamp_axis(bx_sum_s, X_MIN, X_MAX);
                  y_d      = clamp_axis(by_sum_s, Y_MIN, Y_MAX);
                  dx_neg_d = dx_neg_q ^ out_of_range(bx_sum_s, X_MIN, X_MAX);
                  dy_neg_d = dy_neg_q ^ out_of_range(by_sum_s, Y_MIN, Y_MAX);
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else begin
         state_d = state_q;
      end
   end

   // State, position, direction and update-pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vs3_q       <= 1'b0;
         fill_q      <= 2'b00;
         armed_q     <= 1'b0;
         state_q     <= ST_IDLE;
         x_q         <= X_RST;
         y_q         <= Y_RST;
         dx_neg_q    <= 1'b0;
         dy_neg_q    <= 1'b0;
         frame_upd_q <= 1'b0;
      end else begin
         vs3_q       <= vs3_d;
         fill_q      <= fill_d;
         armed_q     <= armed_d;
         state_q     <= state_d;
         x_q         <= x_d;
         y_q         <= y_d;
         dx_neg_q    <= dx_neg_d;
         dy_neg_q    <= dy_neg_d;
         frame_upd_q <= frame_upd_d;
      end
   end

   assign xPixel    = x_q;
   assign yPixel    = y_q;
   assign frame_upd = frame_upd_q;
   assign state_o   = state_q;

endmodule
